regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-read register file with a per-register pending scoreboard.
//  Generalises the fixed 8x32 file: width and depth are parameters, r0 hardwiring
//  and write-through bypass are selectable.
//  Adds a post-reset clear sweep and load-use hazard tracking.
//  Sits between decode (reads, set_pend) and writeback (we/wa/wd) in the core.
// PARAMETERS
//  XLEN      32  data width of each register
//  NREGS     8   number of registers; power of 2, >=2; AW = $clog2(NREGS)
//  ZERO_REG  1   1: reg 0 reads 0, never written, never pending
//  BYPASS    1   1: same-cycle write data forwarded to reads (write-through)
// PORTS
//  clk       in   1     clock, all state updates on posedge
//  rst       in   1     synchronous reset, active-high
//  we        in   1     write enable (writeback)
//  wa        in   AW    write address
//  wd        in   XLEN  write data
//  ra1       in   AW    read address port 1
//  ra2       in   AW    read address port 2
//  rd1       out  XLEN  read data port 1 (combinational)
//  rd2       out  XLEN  read data port 2 (combinational)
//  set_pend  in   1     mark register sa as awaiting an in-flight result
//  sa        in   AW    scoreboard set address
//  pend1     out  1     register ra1 pending (hazard)
//  pend2     out  1     register ra2 pending (hazard)
//  busy      out  1     clear sweep in progress; writes/set_pend ignored
// BEHAVIOUR
//  - FSM states CLEAR, RUN. rst sampled high: state<=CLEAR, idx<=0, all pend<=0.
//  - CLEAR (rst low): each edge rf[idx]<=0, idx<=idx+1; edge with idx==NREGS-1
//    -> RUN. busy = (state==CLEAR), so busy is 1 during rst and for exactly
//    NREGS cycles after rst falls. rst asserted mid-sweep restarts at idx 0.
//  - In CLEAR: we and set_pend ignored; rd1/rd2 = 0; pend1/pend2 = 0.
//  - In RUN: write effective we_eff = we & ~(ZERO_REG & wa==0); rf[wa]<=wd on edge.
//  - Read: if ZERO_REG & ra==0 -> 0; else if BYPASS & we_eff & wa==ra -> wd;
//    else rf[ra]. BYPASS=0: new data visible the cycle after the write edge.
//  - Scoreboard (RUN): we_eff clears pend[wa]; set_pend & ~(ZERO_REG & sa==0)
//    sets pend[sa]. Same address both in one cycle: set wins (result stays 1).
//  - pendN = pend[raN] & ~(BYPASS & we_eff & wa==raN); 0 for r0 when ZERO_REG.
//  - Both read ports independent; ra1==ra2 legal, same result on both.
//  - Reset values: rd1=rd2=0, pend1=pend2=0, busy=1. No X on any output after rst.
// TESTING
//  1 rst 2 cycles, release, count busy -> busy high exactly NREGS(8) cycles;
//    all regs then read 0; we during busy (wa=3,wd=5) -> r3 still 0.
//  2 RUN: we wa=5 wd=0xDEADBEEF, ra1=5 same cycle -> BYPASS=1: rd1=0xDEADBEEF
//    same cycle; BYPASS=0: rd1=0 then 0xDEADBEEF next cycle.
//  3 we wa=0 wd=0x1234, ra1=0 -> rd1=0 (ZERO_REG=1); ZERO_REG=0 -> r0 reads 0x1234.
//  4 set_pend sa=2 -> pend1 (ra1=2) =1 next cycle; we wa=2 -> pend1=0 same cycle
//    (BYPASS=1), pend bit clear after edge; set_pend sa=2 + we wa=2 same cycle -> pend stays 1.
//  5 write r4=0x55, assert rst at sweep idx 3, release -> busy 8 more cycles,
//    r4 reads 0, all pend 0.
//  6 Randomised: XLEN=16, NREGS=16, 10k cycles of we/set_pend/reads vs. ref model.

Source files
------------

// File: rtl/regfile_sb.sv
// Parametrised multi-read register file with a per-register pending scoreboard,
// a post-reset clear sweep, and optional r0 hardwiring / write-through bypass.
module regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 8,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            set_pend,
  input  logic [AW-1:0]   sa,
  output logic            pend1,
  output logic            pend2,
  output logic            busy
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_t            state;
  logic [AW-1:0]     idx;
  logic [XLEN-1:0]   rf [NREGS];
  logic [NREGS-1:0]  pend;
  logic              run;
  logic              we_eff;
  logic              set_eff;

  assign run  = (state == RUN);
  assign busy = (state == CLEAR);

  always_comb begin
    we_eff  = run && we && !(ZERO_REG && (wa == '0));
    set_eff = run && set_pend && !(ZERO_REG && (sa == '0));

    rd1   = '0;
    pend1 = 1'b0;
    if (run && !(ZERO_REG && (ra1 == '0))) begin
      if (BYPASS && we_eff && (wa == ra1)) begin
        rd1 = wd;
      end else begin
        rd1   = rf[ra1];
        pend1 = pend[ra1];
      end
    end

    rd2   = '0;
    pend2 = 1'b0;
    if (run && !(ZERO_REG && (ra2 == '0))) begin
      if (BYPASS && we_eff && (wa == ra2)) begin
        rd2 = wd;
      end else begin
        rd2   = rf[ra2];
        pend2 = pend[ra2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      idx   <= '0;
      pend  <= '0;
    end else if (state == CLEAR) begin
      rf[idx] <= '0;
      idx     <= idx + 1'b1;
      if (idx == LAST) state <= RUN;
    end else begin
      if (we_eff) begin
        rf[wa]   <= wd;
        pend[wa] <= 1'b0;
      end
      // Set is issued after clear so a same-address set wins.
      if (set_eff) pend[sa] <= 1'b1;
    end
  end

endmodule
